// File: rtl/servo_pkg.sv
// Shared types and default constants for the servo PWM controller.
package servo_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } state_e;

  localparam int unsigned DefPeriodCyc = 1000000;
  localparam int unsigned DefMinCyc    = 50000;
  localparam int unsigned DefStepCyc   = 196;
  localparam int unsigned DefMaxCyc    = 100000;
  localparam int unsigned DefCenterPos = 128;
  localparam int unsigned DefRampStep  = 4;

  // Move cur toward tgt by at most step, landing exactly on tgt.
  function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt,
                                             input logic [7:0] step);
    if (tgt > cur) begin
      return ((tgt - cur) > step) ? cur + step : tgt;
    end else begin
      return ((cur - tgt) > step) ? cur - step : tgt;
    end
  endfunction

endpackage

// File: rtl/servo_width_calc.sv
// Pulse width from position: MIN_CYC + pos*STEP_CYC, clamped to MAX_CYC. Pure combinational.
module servo_width_calc #(
  parameter int unsigned MIN_CYC  = 50000,
  parameter int unsigned STEP_CYC = 196,
  parameter int unsigned MAX_CYC  = 100000,
  parameter int unsigned WidthW   = 17
) (
  input  logic [7:0]        pos,
  output logic [WidthW-1:0] width
);

  logic [63:0] raw;

  always_comb begin
    raw   = 64'(MIN_CYC) + 64'(pos) * 64'(STEP_CYC);
    width = (raw > 64'(MAX_CYC)) ? WidthW'(MAX_CYC) : WidthW'(raw);
  end

endmodule

// File: rtl/servo_pwm_ctrl.sv
// Servo PWM frame generator with a one-deep command slot.
// Define SERVO_RAMP_EN to slew the active position by at most RAMP_STEP per frame.
module servo_pwm_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_CYC = DefPeriodCyc,
  parameter int unsigned MIN_CYC    = DefMinCyc,
  parameter int unsigned STEP_CYC   = DefStepCyc,
  parameter int unsigned MAX_CYC    = DefMaxCyc,
  parameter int unsigned CENTER_POS = DefCenterPos,
  parameter int unsigned RAMP_STEP  = DefRampStep
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_pos,
  output logic       cmd_ready,
  output logic       pwm,
  output logic       frame_start,
  output logic       busy
);

  localparam int unsigned CntW   = $clog2(PERIOD_CYC);
  localparam int unsigned WidthW = $clog2(MAX_CYC + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(PERIOD_CYC - 1);
  localparam logic [7:0] CenterPos = 8'(CENTER_POS);

  if (RAMP_STEP == 0 || RAMP_STEP > 255) begin : g_bad_ramp
    $error("RAMP_STEP must be in 1..255");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [WidthW-1:0] width_q, width_d, width_calc;
  logic [7:0]        active_q, active_d, pending_q, pending_d, next_active;
  logic              pending_full_q, pending_full_d;
  logic              pwm_q, pwm_d, fs_q, fs_d, start;

`ifdef SERVO_RAMP_EN
  logic [7:0] target_q, next_target;

  assign next_target = pending_full_q ? pending_q : target_q;
  assign next_active = ramp_toward(active_q, next_target, 8'(RAMP_STEP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= CenterPos;
    end else if (start) begin
      target_q <= next_target;
    end
  end
`else
  // Without ramping the target register is the active position itself.
  assign next_active = pending_full_q ? pending_q : active_q;
`endif

  servo_width_calc #(
    .MIN_CYC  (MIN_CYC),
    .STEP_CYC (STEP_CYC),
    .MAX_CYC  (MAX_CYC),
    .WidthW   (WidthW)
  ) u_width_calc (
    .pos   (next_active),
    .width (width_calc)
  );

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    width_d        = width_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    fs_d           = 1'b0;
    start          = 1'b0;

    unique case (state_q)
      StIdle: start = enable;
      StHigh, StLow: begin
        if (count_q == LastCnt) begin
          if (enable) begin
            start = 1'b1;
          end else begin
            state_d = StIdle;
            count_d = '0;
          end
        end else begin
          count_d = count_q + CntW'(1);
          if (state_q == StHigh && 32'(count_d) >= 32'(width_q)) state_d = StLow;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d        = StHigh;
      count_d        = '0;
      fs_d           = 1'b1;
      active_d       = next_active;
      width_d        = width_calc;
      pending_full_d = 1'b0;
    end

    // Only an empty slot accepts, so a start-cycle accept survives to the next frame.
    if (cmd_valid && !pending_full_q) begin
      pending_d      = cmd_pos;
      pending_full_d = 1'b1;
    end

    pwm_d = (state_d == StHigh) && (32'(count_d) < 32'(width_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      count_q        <= '0;
      width_q        <= '0;
      active_q       <= CenterPos;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      pwm_q          <= 1'b0;
      fs_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      width_q        <= width_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      pwm_q          <= pwm_d;
      fs_q           <= fs_d;
    end
  end

  assign cmd_ready   = !pending_full_q;
  assign pwm         = pwm_q;
  assign frame_start = fs_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_servo_pwm_ctrl.sv
// Directed bench for servo_pwm_ctrl with a short 400-cycle frame.
module tb_servo_pwm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_pos = 8'd0;
  logic       cmd_ready, pwm, frame_start, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  servo_pwm_ctrl #(
    .PERIOD_CYC (400),
    .MIN_CYC    (20),
    .STEP_CYC   (1),
    .MAX_CYC    (200),
    .CENTER_POS (128),
    .RAMP_STEP  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .cmd_valid   (cmd_valid),
    .cmd_pos     (cmd_pos),
    .cmd_ready   (cmd_ready),
    .pwm         (pwm),
    .frame_start (frame_start),
    .busy        (busy)
  );

  // Counts pwm-high and total cycles from the current point to the next frame_start.
  task automatic measure(input int pre_hi, input int pre_len, output int hi, output int len);
    hi  = pre_hi;
    len = pre_len;
    do begin
      if (pwm === 1'b1) hi++;
      len++;
      @(negedge clk);
    end while (frame_start !== 1'b1 && len < 2000);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %b expected 0", pwm); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_enable: busy got %b expected 0", busy); end
  endtask

  task automatic test_start();
    int hi, len;
    enable = 1'b1;
    @(negedge clk);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL start_fs: got %b expected 1", frame_start); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", busy); end
    measure(0, 0, hi, len);
    checks++; if (hi !== 148) begin errors++; $display("FAIL center_pulse: got %0d expected 148", hi); end
    checks++; if (len !== 400) begin errors++; $display("FAIL period: got %0d expected 400", len); end
  endtask

  task automatic test_cmd();
    int hi, len, bad, n;
    int p0;
    repeat (50) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_pos   = 8'd50;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_drop: got %b expected 0", cmd_ready); end
    cmd_valid = 1'b1;
    cmd_pos   = 8'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    bad = 0;
    n   = 0;
    while (frame_start !== 1'b1 && n < 1000) begin
      if (cmd_ready !== 1'b0) bad++;
      n++;
      @(negedge clk);
    end
    checks++; if (bad !== 0 || n >= 1000) begin errors++; $display("FAIL ready_held: got %0d early-ready cycles (wait %0d) expected 0", bad, n); end
    p0 = (pwm === 1'b1) ? 1 : 0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_rise: got %b expected 1", cmd_ready); end
    measure(p0, 1, hi, len);
    checks++; if (hi !== 70) begin errors++; $display("FAIL cmd50_pulse: got %0d expected 70", hi); end
    checks++; if (len !== 400) begin errors++; $display("FAIL cmd50_period: got %0d expected 400", len); end
  endtask

  task automatic test_clamp();
    int hi, len;
    hi = 0;
    // Present the command on the last cycle so it is accepted on the frame-start edge.
    for (int i = 0; i < 400; i++) begin
      if (pwm === 1'b1) hi++;
      if (i == 399) begin
        cmd_valid = 1'b1;
        cmd_pos   = 8'd255;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++; if (hi !== 70) begin errors++; $display("FAIL repeat70_pulse: got %0d expected 70", hi); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL clamp_fs: got %b expected 1", frame_start); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL start_accept_ready: got %b expected 0", cmd_ready); end
    measure(0, 0, hi, len);
    checks++; if (hi !== 70) begin errors++; $display("FAIL start_accept_pending: got %0d expected 70", hi); end
    measure(0, 0, hi, len);
    checks++; if (hi !== 200) begin errors++; $display("FAIL clamp_pulse: got %0d expected 200", hi); end
    checks++; if (len !== 400) begin errors++; $display("FAIL clamp_period: got %0d expected 400", len); end
  endtask

  task automatic test_ramp();
    int hi, len, p0;
    int exp_hi[4] = '{152, 156, 160, 160};
    p0 = (pwm === 1'b1) ? 1 : 0;
    cmd_valid = 1'b1;
    cmd_pos   = 8'd140;
    @(negedge clk);
    cmd_valid = 1'b0;
    measure(p0, 1, hi, len);
    checks++; if (hi !== 148) begin errors++; $display("FAIL ramp_hold: got %0d expected 148", hi); end
    for (int k = 0; k < 4; k++) begin
      measure(0, 0, hi, len);
      checks++; if (hi !== exp_hi[k]) begin errors++; $display("FAIL ramp_step%0d: got %0d expected %0d", k, hi, exp_hi[k]); end
    end
  endtask

  task automatic test_enable_drop();
    int len, extra;
    len   = 0;
    extra = 0;
    while (busy === 1'b1 && len < 1000) begin
      if (len == 100) enable = 1'b0;
      if (len > 0 && frame_start === 1'b1) extra++;
      len++;
      @(negedge clk);
    end
    checks++; if (len !== 400) begin errors++; $display("FAIL drop_frame_len: got %0d expected 400", len); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL drop_no_restart: got %0d starts expected 0", extra); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b expected 0", busy); end
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL drop_pwm: got %b expected 0", pwm); end
  endtask

  task automatic test_reset_mid();
    int hi, len;
    enable = 1'b1;
    @(negedge clk);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL restart_fs: got %b expected 1", frame_start); end
    repeat (10) @(negedge clk);
    checks++; if (pwm !== 1'b1) begin errors++; $display("FAIL mid_pwm_high: got %b expected 1", pwm); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL async_reset_pwm: got %b expected 0", pwm); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b expected 0", busy); end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b expected 0", busy); end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL post_reset_fs: got %b expected 1", frame_start); end
    measure(0, 0, hi, len);
    checks++; if (hi !== 148) begin errors++; $display("FAIL post_reset_center: got %0d expected 148", hi); end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
`ifdef SERVO_RAMP_EN
    test_ramp();
`else
    test_cmd();
    test_clamp();
`endif
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
